// File: rtl/regfile_pkg.sv
// Shared constants, clear-engine state encoding and a constant clog2 helper
// for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  // Ceiling log2, used for address widths at elaboration time
  function automatic int clog2(input int n);
    int v;
    int r;
    v = 32'sd1;
    r = 32'sd0;
    while (v < n) begin
      v = v * 32'sd2;
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks the array one entry per cycle writing zero,
// so a context flush does not need a reset.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int AW       = clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_req,
  output logic          sweep_we,
  output logic [AW-1:0] sweep_addr,
  output logic          clr_busy,
  output logic          clr_done
);

  // Entry 0 is hard-wired when ZERO_REG is set, so the sweep skips it
  localparam logic [AW-1:0] PTR_ONE   = AW'(32'd1);
  localparam logic [AW-1:0] PTR_START = (ZERO_REG != 0) ? AW'(32'd1) : AW'(32'd0);
  localparam logic [AW-1:0] PTR_LAST  = AW'(NREGS - 1);

  clr_state_e      state_r;
  logic [AW-1:0]   ptr_r;
  logic            done_r;

  // Clear FSM: state, sweep pointer and the registered done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      ptr_r   <= AW'(32'd0);
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (clr_req) begin
            state_r <= SWEEP;
            ptr_r   <= PTR_START;
          end
        end
        SWEEP: begin
          if (ptr_r == PTR_LAST) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
          end else begin
            ptr_r  <= ptr_r + PTR_ONE;
            done_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sweep_we   = (state_r == SWEEP);
  assign sweep_addr = ptr_r;
  assign clr_busy   = (state_r == SWEEP);
  assign clr_done   = done_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with same-cycle write-to-read bypass
// and a sequential clear engine for context flush.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  logic [XLEN-1:0] regs_r [NREGS];
  logic            sweep_we_s;
  logic [AW-1:0]   sweep_addr_s;
  logic [NRD-1:0]  byp_hit_s;
  logic [XLEN-1:0] byp_data_s [NRD];
  logic            byp_en_s;

  regfile_clr_fsm #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_clr_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_req    (clr_req),
    .sweep_we   (sweep_we_s),
    .sweep_addr (sweep_addr_s),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done)
  );

  // Array update: sweep owns the array while busy; otherwise later write ports override earlier ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (clr_busy) begin
      if (sweep_we_s) begin
        regs_r[sweep_addr_s] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && !((ZERO_REG != 0) && (wa[j*AW +: AW] == AW'(32'd0)))) begin
          regs_r[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Bypass is suppressed during a sweep and while reset is held so rd stays clean
  assign byp_en_s = (BYPASS != 0) && !clr_busy && reset_n;

  // Bypass match per read port; the highest-index matching write port wins
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      byp_hit_s[k]  = 1'b0;
      byp_data_s[k] = '0;
      for (int j = 0; j < NWR; j++) begin
        byp_hit_s[k]  = (we[j] && (wa[j*AW +: AW] == ra[k*AW +: AW])) ? 1'b1 : byp_hit_s[k];
        byp_data_s[k] = (we[j] && (wa[j*AW +: AW] == ra[k*AW +: AW])) ? wd[j*XLEN +: XLEN]
                                                                    : byp_data_s[k];
      end
    end
  end

  // Read data select: hard zero, then bypass, then stored entry
  always_comb begin
    rd = '0;
    for (int k = 0; k < NRD; k++) begin
      if ((ZERO_REG != 0) && (ra[k*AW +: AW] == AW'(32'd0))) begin
        rd[k*XLEN +: XLEN] = '0;
      end else if (byp_en_s && byp_hit_s[k]) begin
        rd[k*XLEN +: XLEN] = byp_data_s[k];
      end else begin
        rd[k*XLEN +: XLEN] = regs_r[ra[k*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: reset, bypass, write conflict,
// zero register, clear sweep and reset during a sweep.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD*XLEN-1:0] rd_nz;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic                clr_req;
  logic                clr_busy, clr_done;
  logic                busy_nz, done_nz;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(0), .BYPASS(1)) dut_nz (
    .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_nz), .we(we), .wa(wa), .wd(wd),
    .clr_req(clr_req), .clr_busy(busy_nz), .clr_done(done_nz)
  );

  function automatic logic [XLEN-1:0] rdp(input int k);
    return rd[k*XLEN +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] rdp_nz(input int k);
    return rd_nz[k*XLEN +: XLEN];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    we = '0;
    wa = '0;
    wd = '0;
  endtask

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    ra[k*AW +: AW] = a;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we[p]               = 1'b1;
    wa[p*AW +: AW]      = a;
    wd[p*XLEN +: XLEN]  = d;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    clr_req = 1'b0;
    ra      = '0;
    idle_inputs();
    #1 reset_n = 1'b0;
    #2;
    tests_run++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: got busy=%b done=%b expected 0 0", clr_busy, clr_done);
    end
    tests_run++;
    if (rd !== '0) begin
      tests_failed++;
      $display("FAIL reset_rd: got %h expected 0", rd);
    end
    #4 reset_n = 1'b1;
    tick();
    wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    idle_inputs();
    set_ra(0, 5'd5);
    #1;
    tests_run++;
    if (rdp(0) !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL reset_prewrite: got %h expected deadbeef", rdp(0));
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (rdp(0) !== 32'h0 || clr_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: got rd=%h busy=%b expected 0 0", rdp(0), clr_busy);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass;
    set_ra(1, 5'd7);
    wr(0, 5'd7, 32'h1234);
    #1;
    tests_run++;
    if (rdp(1) !== 32'h1234) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: got %h expected 00001234", rdp(1));
    end
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (rdp(1) !== 32'h1234) begin
      tests_failed++;
      $display("FAIL bypass_stored: got %h expected 00001234", rdp(1));
    end
  endtask

  task automatic test_conflict;
    set_ra(0, 5'd9);
    wr(0, 5'd9, 32'hAAAA);
    wr(1, 5'd9, 32'h5555);
    #1;
    tests_run++;
    if (rdp(0) !== 32'h5555) begin
      tests_failed++;
      $display("FAIL conflict_bypass: got %h expected 00005555", rdp(0));
    end
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (rdp(0) !== 32'h5555) begin
      tests_failed++;
      $display("FAIL conflict_stored: got %h expected 00005555", rdp(0));
    end
  endtask

  task automatic test_zero_reg;
    set_ra(0, 5'd0);
    wr(0, 5'd0, 32'hFFFFFFFF);
    #1;
    tests_run++;
    if (rdp(0) !== 32'h0 || rdp_nz(0) !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL zero_bypass: got zr=%h nz=%h expected 00000000 ffffffff", rdp(0), rdp_nz(0));
    end
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (rdp(0) !== 32'h0 || rdp_nz(0) !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL zero_stored: got zr=%h nz=%h expected 00000000 ffffffff", rdp(0), rdp_nz(0));
    end
  endtask

  task automatic test_clear_sweep;
    int busy_cnt, done_cnt, nz_cnt, overlap;
    for (int i = 1; i < NREGS; i++) begin
      wr(0, AW'(i), XLEN'(i));
      tick();
    end
    idle_inputs();
    set_ra(0, 5'd31);
    set_ra(1, 5'd3);
    #1;
    tests_run++;
    if (rdp(0) !== 32'd31 || rdp(1) !== 32'd3) begin
      tests_failed++;
      $display("FAIL sweep_fill: got %h %h expected 0000001f 00000003", rdp(0), rdp(1));
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; nz_cnt = 0; overlap = 0;
    for (int c = 0; c < 40; c++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (clr_done && clr_busy) overlap++;
      if (busy_nz) nz_cnt++;
      if (c == 4) begin
        wr(0, 5'd3, 32'h77);
        set_ra(0, 5'd3);
        #1;
        tests_run++;
        if (rdp(0) !== 32'h0) begin
          tests_failed++;
          $display("FAIL sweep_no_bypass: got %h expected 0", rdp(0));
        end
      end
      if (c == 9) clr_req = 1'b1;
      tick();
      idle_inputs();
      clr_req = 1'b0;
    end
    tests_run++;
    if (busy_cnt !== 31 || nz_cnt !== 32) begin
      tests_failed++;
      $display("FAIL sweep_length: got zr=%0d nz=%0d expected 31 32", busy_cnt, nz_cnt);
    end
    tests_run++;
    if (done_cnt !== 1 || overlap !== 0) begin
      tests_failed++;
      $display("FAIL sweep_done: got pulses=%0d overlap=%0d expected 1 0", done_cnt, overlap);
    end
    for (int i = 0; i < NREGS; i++) begin
      set_ra(0, AW'(i));
      #1;
      tests_run++;
      if (rdp(0) !== 32'h0 || rdp_nz(0) !== 32'h0) begin
        tests_failed++;
        $display("FAIL sweep_cleared[%0d]: got zr=%h nz=%h expected 0 0", i, rdp(0), rdp_nz(0));
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    int done_cnt, busy_cnt;
    wr(0, 5'd20, 32'hCAFE);
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    tests_run++;
    if (clr_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_busy_before: got %b expected 1", clr_busy);
    end
    #2 reset_n = 1'b0;
    set_ra(0, 5'd20);
    #1;
    tests_run++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0 || busy_nz !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_status: got busy=%b done=%b nzbusy=%b expected 0 0 0",
               clr_busy, clr_done, busy_nz);
    end
    tests_run++;
    if (rdp(0) !== 32'h0 || rdp_nz(0) !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_entry20: got zr=%h nz=%h expected 0 0", rdp(0), rdp_nz(0));
    end
    reset_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (clr_done || done_nz) done_cnt++;
      if (clr_busy || busy_nz) busy_cnt++;
    end
    tests_run++;
    if (done_cnt !== 0 || busy_cnt !== 0) begin
      tests_failed++;
      $display("FAIL midreset_after: got done=%0d busy=%0d expected 0 0", done_cnt, busy_cnt);
    end
    for (int i = 0; i < NREGS; i++) begin
      set_ra(1, AW'(i));
      #1;
      tests_run++;
      if (rdp(1) !== 32'h0 || rdp_nz(1) !== 32'h0) begin
        tests_failed++;
        $display("FAIL midreset_zero[%0d]: got zr=%h nz=%h expected 0 0", i, rdp(1), rdp_nz(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_zero_reg();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
